rx_stream_pattern_matcher: RTL and testbench

Second-generation receive-side streaming pattern matcher on the `clk_net` 64-bit datapath. It tags each packet with the ID of the first programmed (type, symbol) pair found at configurable byte offsets. Offsets need not be word-aligned, and fields may straddle word boundaries. The packet stream passes through with a fixed 2-cycle delay so the tag lands on the EOP word at the RX FIFO input. No packet storage is used.

---
 rtl/rx_stream_pattern_matcher.sv | 206 ++++++++++++++++++++
 tb/tb_rx_stream_pattern_matcher.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_stream_pattern_matcher.sv
// Receive-side streaming matcher: tags each packet with the first programmed (type, symbol)
// pair found at fixed byte offsets; the word stream passes through with a 2-cycle delay.
module rx_stream_pattern_matcher #(
  parameter int unsigned NUM_PATTERNS  = 4,
  parameter int unsigned TYPE_OFFSET   = 16,
  parameter int unsigned SYMBOL_OFFSET = 24
) (
  input  logic                            clk_net,
  input  logic                            rst_n,
  input  logic                            in_valid,
  input  logic                            in_sop,
  input  logic                            in_eop,
  input  logic [2:0]                      in_length,
  input  logic [63:0]                     in_data,
  input  logic                            cfg_we,
  input  logic [$clog2(NUM_PATTERNS)-1:0] cfg_idx,
  input  logic                            cfg_enable,
  input  logic [31:0]                     cfg_type,
  input  logic [63:0]                     cfg_symbol,
  output logic                            out_valid,
  output logic                            out_sop,
  output logic                            out_eop,
  output logic [2:0]                      out_length,
  output logic [63:0]                     out_data,
  output logic [7:0]                      out_tag,
  output logic                            out_tag_valid,
  output logic [31:0]                     stat_pkts,
  output logic [31:0]                     stat_hits
);
  localparam int unsigned IDX_W   = $clog2(NUM_PATTERNS);
  localparam int unsigned POS_W   = 11;
  localparam int unsigned TYPE_B  = 4;
  localparam int unsigned SYM_B   = 8;
  localparam logic [POS_W-1:0] POS_SAT = POS_W'(2040);

  typedef struct packed {
    logic        valid;
    logic        sop;
    logic        eop;
    logic [2:0]  length;
    logic [63:0] data;
  } word_t;

  typedef enum logic [0:0] {ST_IDLE, ST_PKT} state_t;

  state_t             state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [31:0]        type_q, type_d;
  logic [TYPE_B-1:0]  tmask_q, tmask_d;
  logic [63:0]        sym_q, sym_d;
  logic [SYM_B-1:0]   smask_q, smask_d;
  logic               accept;
  logic [POS_W-1:0]   base;
  logic [3:0]         nbytes;
  logic [POS_W:0]     pos_nxt;
  word_t              in_word, s1_q;
  logic               s1_tag_ok_q;
  logic [7:0]         tag_c;

  logic               wk_en   [NUM_PATTERNS];
  logic [31:0]        wk_type [NUM_PATTERNS];
  logic [63:0]        wk_sym  [NUM_PATTERNS];
  logic               sh_en   [NUM_PATTERNS];
  logic [31:0]        sh_type [NUM_PATTERNS];
  logic [63:0]        sh_sym  [NUM_PATTERNS];

  assign in_word = {in_valid, in_sop, in_eop, in_length, in_data};

  // Packet tracking and field capture; an SOP clears the accumulators before its own bytes land.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    type_d  = type_q;
    tmask_d = tmask_q;
    sym_d   = sym_q;
    smask_d = smask_q;
    accept  = 1'b0;
    base    = '0;
    nbytes  = 4'd8;
    pos_nxt = '0;
    if (in_valid && in_sop) begin
      accept  = 1'b1;
      type_d  = '0;
      tmask_d = '0;
      sym_d   = '0;
      smask_d = '0;
    end else if (in_valid && state_q == ST_PKT) begin
      accept = 1'b1;
      base   = pos_q;
    end
    if (in_eop && in_length != 3'd0) nbytes = {1'b0, in_length};
    if (accept) begin
      for (int k = 0; k < 8; k++) begin
        if (4'(k) < nbytes) begin
          for (int j = 0; j < int'(TYPE_B); j++) begin
            if ({1'b0, base} + 12'(k) == 12'(TYPE_OFFSET + j)) begin
              type_d[8*j +: 8] = in_data[8*k +: 8];
              tmask_d[j]       = 1'b1;
            end
          end
          for (int j = 0; j < int'(SYM_B); j++) begin
            if ({1'b0, base} + 12'(k) == 12'(SYMBOL_OFFSET + j)) begin
              sym_d[8*j +: 8] = in_data[8*k +: 8];
              smask_d[j]      = 1'b1;
            end
          end
        end
      end
      pos_nxt = {1'b0, base} + 12'd8;
      pos_d   = (pos_nxt > {1'b0, POS_SAT}) ? POS_SAT : pos_nxt[POS_W-1:0];
      state_d = in_eop ? ST_IDLE : ST_PKT;
    end
  end

  // Stage 1: word, post-capture fields and packet state.
  always_ff @(posedge clk_net or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pos_q       <= '0;
      type_q      <= '0;
      tmask_q     <= '0;
      sym_q       <= '0;
      smask_q     <= '0;
      s1_q        <= '0;
      s1_tag_ok_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      type_q      <= type_d;
      tmask_q     <= tmask_d;
      sym_q       <= sym_d;
      smask_q     <= smask_d;
      s1_q        <= in_word;
      s1_tag_ok_q <= accept & in_eop;
    end
  end

  // Working table takes writes at once; the shadow snapshots it on every accepted SOP.
  always_ff @(posedge clk_net or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_PATTERNS); i++) begin
        wk_en[i]   <= 1'b0;
        wk_type[i] <= '0;
        wk_sym[i]  <= '0;
        sh_en[i]   <= 1'b0;
        sh_type[i] <= '0;
        sh_sym[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_PATTERNS); i++) begin
        if (cfg_we && cfg_idx == IDX_W'(i)) begin
          wk_en[i]   <= cfg_enable;
          wk_type[i] <= cfg_type;
          wk_sym[i]  <= cfg_symbol;
        end
        if (in_valid && in_sop) begin
          sh_en[i]   <= wk_en[i];
          sh_type[i] <= wk_type[i];
          sh_sym[i]  <= wk_sym[i];
        end
      end
    end
  end

  // Parallel compares with lowest-index priority.
  always_comb begin
    tag_c = 8'd0;
    if (s1_tag_ok_q && (&tmask_q) && (&smask_q)) begin
      for (int i = int'(NUM_PATTERNS) - 1; i >= 0; i--) begin
        if (sh_en[i] && sh_type[i] == type_q && sh_sym[i] == sym_q) tag_c = 8'(i + 1);
      end
    end
  end

  // Stage 2: outputs.
  always_ff @(posedge clk_net or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_sop       <= 1'b0;
      out_eop       <= 1'b0;
      out_length    <= '0;
      out_data      <= '0;
      out_tag       <= '0;
      out_tag_valid <= 1'b0;
    end else begin
      out_valid     <= s1_q.valid;
      out_sop       <= s1_q.sop;
      out_eop       <= s1_q.eop;
      out_length    <= s1_q.length;
      out_data      <= s1_q.data;
      out_tag       <= tag_c;
      out_tag_valid <= s1_q.valid & s1_q.eop;
    end
  end

  always_ff @(posedge clk_net or negedge rst_n) begin
    if (!rst_n) begin
      stat_pkts <= '0;
      stat_hits <= '0;
    end else if (out_tag_valid) begin
      stat_pkts <= stat_pkts + 32'd1;
      if (out_tag != 8'd0) stat_hits <= stat_hits + 32'd1;
    end
  end

endmodule

// File: tb/tb_rx_stream_pattern_matcher.sv
// Bench for rx_stream_pattern_matcher: two instances (offsets 16/24 and 14/29) share stimulus;
// expected tags come from a byte-array packet model evaluated against the table at SOP time.
`timescale 1ns/1ps
module tb_rx_stream_pattern_matcher;
  logic        clk_net = 1'b0;
  logic        rst_n;
  logic        in_valid, in_sop, in_eop;
  logic [2:0]  in_length;
  logic [63:0] in_data;
  logic        cfg_we, cfg_enable;
  logic [1:0]  cfg_idx;
  logic [31:0] cfg_type;
  logic [63:0] cfg_symbol;

  logic        a_valid, a_sop, a_eop, a_tag_valid;
  logic [2:0]  a_length;
  logic [63:0] a_data;
  logic [7:0]  a_tag;
  logic [31:0] a_pkts, a_hits;
  logic        b_valid, b_sop, b_eop, b_tag_valid;
  logic [2:0]  b_length;
  logic [63:0] b_data;
  logic [7:0]  b_tag;
  logic [31:0] b_pkts, b_hits;

  rx_stream_pattern_matcher #(.NUM_PATTERNS(4), .TYPE_OFFSET(16), .SYMBOL_OFFSET(24)) dut (
    .clk_net(clk_net), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_length(in_length), .in_data(in_data), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_enable(cfg_enable), .cfg_type(cfg_type), .cfg_symbol(cfg_symbol),
    .out_valid(a_valid), .out_sop(a_sop), .out_eop(a_eop), .out_length(a_length),
    .out_data(a_data), .out_tag(a_tag), .out_tag_valid(a_tag_valid),
    .stat_pkts(a_pkts), .stat_hits(a_hits));

  rx_stream_pattern_matcher #(.NUM_PATTERNS(4), .TYPE_OFFSET(14), .SYMBOL_OFFSET(29)) dut2 (
    .clk_net(clk_net), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_length(in_length), .in_data(in_data), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_enable(cfg_enable), .cfg_type(cfg_type), .cfg_symbol(cfg_symbol),
    .out_valid(b_valid), .out_sop(b_sop), .out_eop(b_eop), .out_length(b_length),
    .out_data(b_data), .out_tag(b_tag), .out_tag_valid(b_tag_valid),
    .stat_pkts(b_pkts), .stat_hits(b_hits));

  always #5 clk_net = ~clk_net;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]  pkt[$];
  logic [7:0]  exp_tag_a[$], exp_tag_b[$], obs_tag_a[$], obs_tag_b[$];
  logic [63:0] exp_data[$], obs_data[$];
  int          exp_cyc[$], obs_cyc[$];

  logic        m_en   [4];
  logic [31:0] m_type [4];
  logic [63:0] m_sym  [4];
  int unsigned m_pkts_a, m_hits_a, m_pkts_b, m_hits_b;

  always @(posedge clk_net) cyc <= cyc + 1;

  always @(negedge clk_net) begin
    if (a_tag_valid) begin
      obs_tag_a.push_back(a_tag);
      obs_cyc.push_back(cyc);
    end
    if (b_tag_valid) obs_tag_b.push_back(b_tag);
    if (a_valid) obs_data.push_back(a_data);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t want below 500000", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] model_tag(input int to, input int so);
    logic [31:0] t;
    logic [63:0] s;
    if (pkt.size() < to + 4 || pkt.size() < so + 8) return 8'd0;
    for (int j = 0; j < 4; j++) t[8*j +: 8] = pkt[to+j];
    for (int j = 0; j < 8; j++) s[8*j +: 8] = pkt[so+j];
    for (int i = 0; i < 4; i++)
      if (m_en[i] && m_type[i] == t && m_sym[i] == s) return 8'(i + 1);
    return 8'd0;
  endfunction

  task automatic flush();
    exp_tag_a.delete(); exp_tag_b.delete(); obs_tag_a.delete(); obs_tag_b.delete();
    exp_data.delete(); obs_data.delete(); exp_cyc.delete(); obs_cyc.delete();
  endtask

  task automatic drive_idle();
    @(posedge clk_net); #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic cfg_write(input int idx, input logic en, input logic [31:0] t, input logic [63:0] s);
    @(posedge clk_net); #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_enable = en; cfg_type = t; cfg_symbol = s;
    m_en[idx] = en; m_type[idx] = t; m_sym[idx] = s;
    drive_idle();
  endtask

  task automatic build_pkt(input int n, input int to, input int so,
                           input logic [31:0] t, input logic [63:0] s, input bit place);
    pkt.delete();
    for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
    if (place) begin
      for (int j = 0; j < 4; j++) if (to + j < n) pkt[to+j] = t[8*j +: 8];
      for (int j = 0; j < 8; j++) if (so + j < n) pkt[so+j] = s[8*j +: 8];
    end
  endtask

  // Expected tags are fixed by the table as it stands when the packet starts.
  task automatic send_pkt(input bit do_eop, input int wr_word, input int wr_idx,
                          input logic [31:0] wr_t, input logic [63:0] wr_s);
    int n, nw;
    logic [7:0] ea, eb;
    logic [63:0] d;
    n = pkt.size();
    nw = (n + 7) / 8;
    ea = model_tag(16, 24);
    eb = model_tag(14, 29);
    for (int w = 0; w < nw; w++) begin
      d = {$urandom, $urandom};
      for (int k = 0; k < 8; k++) if (w*8 + k < n) d[8*k +: 8] = pkt[w*8+k];
      @(posedge clk_net); #1;
      in_valid = 1'b1; in_sop = (w == 0); in_eop = do_eop && (w == nw - 1);
      in_length = (w == nw - 1) ? 3'(n % 8) : 3'd0;
      in_data = d;
      cfg_we = (w == wr_word);
      if (w == wr_word) begin
        cfg_idx = 2'(wr_idx); cfg_enable = 1'b1; cfg_type = wr_t; cfg_symbol = wr_s;
        m_en[wr_idx] = 1'b1; m_type[wr_idx] = wr_t; m_sym[wr_idx] = wr_s;
      end
      exp_data.push_back(d);
      if (in_eop) exp_cyc.push_back(cyc);
    end
    if (do_eop) begin
      exp_tag_a.push_back(ea); exp_tag_b.push_back(eb);
      m_pkts_a++; if (ea != 0) m_hits_a++;
      m_pkts_b++; if (eb != 0) m_hits_b++;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    drive_idle();
    while ((obs_tag_a.size() < exp_tag_a.size() || obs_tag_b.size() < exp_tag_b.size() ||
            obs_data.size() < exp_data.size()) && t < 500) begin
      @(negedge clk_net);
      t++;
    end
    checks++;
    if (t >= 500) begin
      errors++;
      $display("FAIL drain_timeout: got %0d tags want %0d", obs_tag_a.size(), exp_tag_a.size());
    end
    repeat (4) @(negedge clk_net);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_length = 3'd0; in_data = '0;
    cfg_we = 1'b0; cfg_idx = 2'd0; cfg_enable = 1'b0; cfg_type = '0; cfg_symbol = '0;
    for (int i = 0; i < 4; i++) begin m_en[i] = 1'b0; m_type[i] = '0; m_sym[i] = '0; end
    m_pkts_a = 0; m_hits_a = 0; m_pkts_b = 0; m_hits_b = 0;
    repeat (3) @(negedge clk_net);
    checks++;
    if ({a_valid, a_sop, a_eop, a_tag_valid, b_valid, b_tag_valid} !== 6'd0) begin
      errors++; $display("FAIL reset_flags: got %b want 000000",
                         {a_valid, a_sop, a_eop, a_tag_valid, b_valid, b_tag_valid});
    end
    checks++;
    if (a_data !== 64'd0 || a_tag !== 8'd0 || a_length !== 3'd0) begin
      errors++; $display("FAIL reset_data: got %h/%h/%h want 0", a_data, a_tag, a_length);
    end
    checks++;
    if (a_pkts !== 32'd0 || a_hits !== 32'd0 || b_pkts !== 32'd0 || b_hits !== 32'd0) begin
      errors++; $display("FAIL reset_stats: got %0d %0d want 0 0", a_pkts, a_hits);
    end
    @(posedge clk_net); #1;
    rst_n = 1'b1;
    flush();
  endtask

  task automatic test_aligned();
    logic [7:0] o, e;
    int oc, ec;
    logic [63:0] od, ed;
    cfg_write(2, 1'b1, 32'hCAFE0001, 64'h1122334455667788);
    build_pkt(48, 16, 24, 32'hCAFE0001, 64'h1122334455667788, 1'b1);
    send_pkt(1'b1, -1, 0, '0, '0);
    drain();
    e = exp_tag_a.pop_front();
    o = (obs_tag_a.size() > 0) ? obs_tag_a.pop_front() : 8'hxx;
    checks++;
    if (o !== e) begin errors++; $display("FAIL aligned_tag_model: got %0d want %0d", o, e); end
    checks++;
    if (o !== 8'd3) begin errors++; $display("FAIL aligned_tag: got %0d want 3", o); end
    ec = exp_cyc.pop_front();
    oc = (obs_cyc.size() > 0) ? obs_cyc.pop_front() : -1;
    checks++;
    if (oc !== ec + 2) begin errors++; $display("FAIL aligned_latency: got cycle %0d want %0d", oc, ec + 2); end
    while (exp_data.size() > 0) begin
      ed = exp_data.pop_front();
      od = (obs_data.size() > 0) ? obs_data.pop_front() : 64'hx;
      checks++;
      if (od !== ed) begin errors++; $display("FAIL aligned_data: got %h want %h", od, ed); end
    end
    checks++;
    if (a_hits !== 32'd1 || a_pkts !== 32'd1) begin
      errors++; $display("FAIL aligned_stats: got pkts %0d hits %0d want 1 1", a_pkts, a_hits);
    end
    flush();
  endtask

  task automatic test_straddle();
    logic [31:0] t;
    logic [63:0] s;
    logic [7:0] o, e;
    logic [7:0] want [2];
    t = $urandom; s = {$urandom, $urandom};
    want[0] = 8'd2; want[1] = 8'd0;
    cfg_write(1, 1'b1, t, s);
    build_pkt(40, 14, 29, t, s, 1'b1);
    send_pkt(1'b1, -1, 0, '0, '0);
    build_pkt(40, 14, 29, t, s, 1'b1);
    pkt[30] = pkt[30] ^ 8'h01;
    send_pkt(1'b1, -1, 0, '0, '0);
    drain();
    for (int i = 0; i < 2; i++) begin
      e = exp_tag_b.pop_front();
      o = (obs_tag_b.size() > 0) ? obs_tag_b.pop_front() : 8'hxx;
      checks++;
      if (o !== e) begin errors++; $display("FAIL straddle_tag_model[%0d]: got %0d want %0d", i, o, e); end
      checks++;
      if (o !== want[i]) begin errors++; $display("FAIL straddle_tag[%0d]: got %0d want %0d", i, o, want[i]); end
      e = exp_tag_a.pop_front();
      o = (obs_tag_a.size() > 0) ? obs_tag_a.pop_front() : 8'hxx;
      checks++;
      if (o !== e) begin errors++; $display("FAIL straddle_other[%0d]: got %0d want %0d", i, o, e); end
    end
    checks++;
    if (b_hits !== 32'(m_hits_b) || b_pkts !== 32'(m_pkts_b)) begin
      errors++; $display("FAIL straddle_stats: got %0d/%0d want %0d/%0d", b_pkts, b_hits, m_pkts_b, m_hits_b);
    end
    flush();
  endtask

  task automatic test_priority();
    logic [31:0] t;
    logic [63:0] s;
    logic [7:0] o, e;
    t = $urandom; s = {$urandom, $urandom};
    cfg_write(0, 1'b1, t, s ^ 64'h1);
    cfg_write(3, 1'b1, t, s);
    build_pkt(48, 16, 24, t, s, 1'b1);
    send_pkt(1'b1, -1, 0, '0, '0);
    drain();
    e = exp_tag_a.pop_front();
    o = (obs_tag_a.size() > 0) ? obs_tag_a.pop_front() : 8'hxx;
    checks++;
    if (o !== e || o !== 8'd4) begin errors++; $display("FAIL priority_pair: got %0d want %0d (4)", o, e); end
    flush();
    cfg_write(0, 1'b1, t, s);
    build_pkt(48, 16, 24, t, s, 1'b1);
    send_pkt(1'b1, -1, 0, '0, '0);
    drain();
    e = exp_tag_a.pop_front();
    o = (obs_tag_a.size() > 0) ? obs_tag_a.pop_front() : 8'hxx;
    checks++;
    if (o !== e || o !== 8'd1) begin errors++; $display("FAIL priority_low: got %0d want %0d (1)", o, e); end
    flush();
  endtask

  task automatic test_short();
    logic [7:0] o;
    logic [31:0] p0, h0;
    p0 = a_pkts; h0 = a_hits;
    build_pkt(27, 16, 24, m_type[0], m_sym[0], 1'b1);
    send_pkt(1'b1, -1, 0, '0, '0);
    drain();
    o = (obs_tag_a.size() > 0) ? obs_tag_a.pop_front() : 8'hxx;
    checks++;
    if (o !== 8'd0) begin errors++; $display("FAIL short_tag: got %0d want 0", o); end
    checks++;
    if (a_pkts !== p0 + 32'd1 || a_hits !== h0) begin
      errors++; $display("FAIL short_stats: got %0d/%0d want %0d/%0d", a_pkts, a_hits, p0 + 1, h0);
    end
    flush();
  endtask

  task automatic test_back_to_back();
    logic [31:0] t0, t1;
    logic [63:0] s0, s1;
    logic [7:0] o, e;
    t0 = m_type[0]; s0 = m_sym[0];
    t1 = $urandom; s1 = {$urandom, $urandom};
    build_pkt(40, 16, 24, t0, s0, 1'b1);
    send_pkt(1'b1, 2, 0, t1, s1);
    build_pkt(40, 16, 24, t1, s1, 1'b1);
    send_pkt(1'b1, -1, 0, '0, '0);
    drain();
    for (int i = 0; i < 2; i++) begin
      e = exp_tag_a.pop_front();
      o = (obs_tag_a.size() > 0) ? obs_tag_a.pop_front() : 8'hxx;
      checks++;
      if (o !== e || o !== 8'd1) begin errors++; $display("FAIL shadow_tag[%0d]: got %0d want %0d (1)", i, o, e); end
    end
    flush();
    build_pkt(40, 16, 24, t1, s1, 1'b1);
    send_pkt(1'b0, -1, 0, '0, '0);
    build_pkt(32, 16, 24, t1, s1, 1'b1);
    send_pkt(1'b1, -1, 0, '0, '0);
    drain();
    checks++;
    if (obs_tag_a.size() !== 1) begin errors++; $display("FAIL abandon_count: got %0d tags want 1", obs_tag_a.size()); end
    o = (obs_tag_a.size() > 0) ? obs_tag_a.pop_front() : 8'hxx;
    checks++;
    if (o !== 8'd1) begin errors++; $display("FAIL abandon_next_tag: got %0d want 1", o); end
    checks++;
    if (a_pkts !== 32'(m_pkts_a) || a_hits !== 32'(m_hits_a)) begin
      errors++; $display("FAIL abandon_stats: got %0d/%0d want %0d/%0d", a_pkts, a_hits, m_pkts_a, m_hits_a);
    end
    flush();
  endtask

  task automatic test_random();
    logic [7:0] o, e;
    int oc, ec, ch, k, n;
    logic [63:0] od, ed;
    for (int i = 0; i < 4; i++) cfg_write(i, ($urandom % 4) != 0, $urandom, {$urandom, $urandom});
    for (int p = 0; p < 24; p++) begin
      n = $urandom_range(1, 56);
      ch = $urandom % 3;
      k = $urandom % 4;
      if (ch == 0) build_pkt(n, 16, 24, m_type[k], m_sym[k], 1'b1);
      else if (ch == 1) build_pkt(n, 14, 29, m_type[k], m_sym[k], 1'b1);
      else build_pkt(n, 0, 0, '0, '0, 1'b0);
      if (($urandom % 5) == 0 && n > 20) pkt[20] = pkt[20] ^ 8'h80;
      send_pkt(1'b1, -1, 0, '0, '0);
      repeat ($urandom % 3) drive_idle();
    end
    drain();
    while (exp_tag_a.size() > 0) begin
      e = exp_tag_a.pop_front();
      o = (obs_tag_a.size() > 0) ? obs_tag_a.pop_front() : 8'hxx;
      checks++;
      if (o !== e) begin errors++; $display("FAIL random_tag_a: got %0d want %0d", o, e); end
      ec = exp_cyc.pop_front();
      oc = (obs_cyc.size() > 0) ? obs_cyc.pop_front() : -1;
      checks++;
      if (oc !== ec + 2) begin errors++; $display("FAIL random_latency: got %0d want %0d", oc, ec + 2); end
    end
    while (exp_tag_b.size() > 0) begin
      e = exp_tag_b.pop_front();
      o = (obs_tag_b.size() > 0) ? obs_tag_b.pop_front() : 8'hxx;
      checks++;
      if (o !== e) begin errors++; $display("FAIL random_tag_b: got %0d want %0d", o, e); end
    end
    while (exp_data.size() > 0) begin
      ed = exp_data.pop_front();
      od = (obs_data.size() > 0) ? obs_data.pop_front() : 64'hx;
      checks++;
      if (od !== ed) begin errors++; $display("FAIL random_data: got %h want %h", od, ed); end
    end
    checks++;
    if (a_pkts !== 32'(m_pkts_a) || a_hits !== 32'(m_hits_a) ||
        b_pkts !== 32'(m_pkts_b) || b_hits !== 32'(m_hits_b)) begin
      errors++; $display("FAIL random_stats: got %0d/%0d %0d/%0d want %0d/%0d %0d/%0d",
                         a_pkts, a_hits, b_pkts, b_hits, m_pkts_a, m_hits_a, m_pkts_b, m_hits_b);
    end
    flush();
  endtask

  task automatic test_reset_mid();
    logic [31:0] t;
    logic [63:0] s, d;
    logic [7:0] o;
    build_pkt(24, 16, 24, m_type[0], m_sym[0], 1'b1);
    send_pkt(1'b0, -1, 0, '0, '0);
    #2 rst_n = 1'b0;
    @(negedge clk_net);
    checks++;
    if ({a_valid, a_tag_valid, b_valid, b_tag_valid} !== 4'd0 || a_data !== 64'd0 || a_tag !== 8'd0) begin
      errors++; $display("FAIL rstmid_outputs: got valid %b data %h want 0", {a_valid, a_tag_valid, b_valid, b_tag_valid}, a_data);
    end
    checks++;
    if (a_pkts !== 32'd0 || a_hits !== 32'd0 || b_pkts !== 32'd0) begin
      errors++; $display("FAIL rstmid_stats: got %0d/%0d want 0/0", a_pkts, a_hits);
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    @(posedge clk_net); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin m_en[i] = 1'b0; m_type[i] = '0; m_sym[i] = '0; end
    m_pkts_a = 0; m_hits_a = 0; m_pkts_b = 0; m_hits_b = 0;
    flush();
    d = {$urandom, $urandom};
    @(posedge clk_net); #1;
    in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b0; in_data = d;
    exp_data.push_back(d);
    t = $urandom; s = {$urandom, $urandom};
    cfg_write(0, 1'b1, t, s);
    build_pkt(48, 16, 24, t, s, 1'b1);
    send_pkt(1'b1, -1, 0, '0, '0);
    drain();
    o = (obs_tag_a.size() > 0) ? obs_tag_a.pop_front() : 8'hxx;
    checks++;
    if (o !== 8'd1) begin errors++; $display("FAIL rstmid_next_tag: got %0d want 1", o); end
    checks++;
    if (obs_data.size() > 0 && obs_data[0] !== d) begin
      errors++; $display("FAIL rstmid_stray_data: got %h want %h", obs_data[0], d);
    end
    checks++;
    if (a_pkts !== 32'd1 || a_hits !== 32'd1) begin
      errors++; $display("FAIL rstmid_stats_after: got %0d/%0d want 1/1", a_pkts, a_hits);
    end
    flush();
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_straddle();
    test_priority();
    test_short();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
